// File: rtl/cdr_pkg.sv
// Shared encodings for the CDR lock sequencer: FSM states, window classes and
// the loop-filter gain-shift width.
package cdr_pkg;
  localparam int GAIN_W = 4;

  typedef logic [GAIN_W-1:0] gain_t;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_ACQ    = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } cdr_state_e;

  typedef enum logic [1:0] {
    CLS_NEUTRAL = 2'd0,
    CLS_QUIET   = 2'd1,
    CLS_NOISY   = 2'd2
  } win_cls_e;

  // TRACK and LOCKED share the narrow-bandwidth gains.
  function automatic logic trk_gain(input cdr_state_e s);
    return (s == ST_TRACK) || (s == ST_LOCKED);
  endfunction
endpackage

// File: rtl/cdr_lock_seq_if.sv
// Phase-detector inputs and loop-filter control outputs of the lock sequencer.
// master = CDR core side, slave = sequencer.
interface cdr_lock_seq_if;
  import cdr_pkg::*;

  logic       sample_en;
  logic       pd_up;
  logic       pd_dn;
  logic       trans;
  gain_t      kp_shift;
  gain_t      ki_shift;
  logic       int_clear;
  logic       loop_hold;
  logic       locked;
  logic [1:0] state;
  logic       win_done;

  modport master (
    output sample_en, pd_up, pd_dn, trans,
    input  kp_shift, ki_shift, int_clear, loop_hold, locked, state, win_done
  );

  modport slave (
    input  sample_en, pd_up, pd_dn, trans,
    output kp_shift, ki_shift, int_clear, loop_hold, locked, state, win_done
  );
endinterface

// File: rtl/cdr_win_acc.sv
// Fixed-length window accumulator: net early/late balance and transition count
// over 2^WIN_LOG2 baud strobes, classified when the window closes.
module cdr_win_acc
  import cdr_pkg::*;
#(
  parameter int WIN_LOG2  = 8,
  parameter int LOCK_THR  = 16,
  parameter int MIN_TRANS = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clr,
  input  logic     sample_en,
  input  logic     pd_up,
  input  logic     pd_dn,
  input  logic     trans,
  output logic     win_done,
  output win_cls_e cls
);
  localparam int NW = WIN_LOG2 + 2;
  localparam int TW = WIN_LOG2 + 1;

  logic [WIN_LOG2-1:0] win_cnt;
  logic signed [NW-1:0] net, net_f;
  logic [TW-1:0]       tcnt, tcnt_f;
  logic [NW-1:0]       mag;
  logic                last;
  win_cls_e            cls_f;

  // Final values include the current strobe so the closing strobe counts.
  always_comb begin
    net_f = net;
    if (pd_up && !pd_dn)      net_f = net + NW'(1);
    else if (pd_dn && !pd_up) net_f = net - NW'(1);
    tcnt_f = tcnt + TW'(trans);
    mag    = net_f[NW-1] ? NW'(-net_f) : NW'(net_f);
    last   = (win_cnt == '1);
    if (tcnt_f < TW'(MIN_TRANS))  cls_f = CLS_NEUTRAL;
    else if (mag <= NW'(LOCK_THR)) cls_f = CLS_QUIET;
    else                           cls_f = CLS_NOISY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt  <= '0;
      net      <= '0;
      tcnt     <= '0;
      win_done <= 1'b0;
      cls      <= CLS_NEUTRAL;
    end else if (clr) begin
      win_cnt  <= '0;
      net      <= '0;
      tcnt     <= '0;
      win_done <= 1'b0;
      cls      <= CLS_NEUTRAL;
    end else begin
      win_done <= 1'b0;
      if (sample_en) begin
        win_cnt <= win_cnt + WIN_LOG2'(1);
        if (last) begin
          net      <= '0;
          tcnt     <= '0;
          win_done <= 1'b1;
          cls      <= cls_f;
        end else begin
          net  <= net_f;
          tcnt <= tcnt_f;
        end
      end
    end
  end
endmodule

// File: rtl/cdr_lock_seq.sv
// Bang-bang CDR acquisition/lock sequencer: gear-shifts loop gains from ACQ to
// TRACK, declares/drops lock and clears or freezes the loop integrator.
module cdr_lock_seq
  import cdr_pkg::*;
#(
  parameter int WIN_LOG2    = 8,
  parameter int LOCK_THR    = 16,
  parameter int MIN_TRANS   = 32,
  parameter int ACQ_WINS    = 2,
  parameter int LOCK_WINS   = 4,
  parameter int UNLOCK_WINS = 2,
  parameter int KP_ACQ      = 3,
  parameter int KI_ACQ      = 6,
  parameter int KP_TRK      = 5,
  parameter int KI_TRK      = 10
) (
  input logic           clk,
  input logic           rst_n,
  input logic           ena,
  cdr_lock_seq_if.slave cdr
);
  localparam int RUN_W = 8;
  localparam logic [RUN_W-1:0] ACQ_N  = RUN_W'(ACQ_WINS);
  localparam logic [RUN_W-1:0] LOCK_N = RUN_W'(LOCK_WINS);
  localparam logic [RUN_W-1:0] UNL_N  = RUN_W'(UNLOCK_WINS);
  localparam gain_t KP_A = GAIN_W'(KP_ACQ);
  localparam gain_t KI_A = GAIN_W'(KI_ACQ);
  localparam gain_t KP_T = GAIN_W'(KP_TRK);
  localparam gain_t KI_T = GAIN_W'(KI_TRK);

  cdr_state_e       cur, nxt;
  logic [RUN_W-1:0] quiet_run, noisy_run, quiet_upd, noisy_upd, quiet_nxt, noisy_nxt;
  logic             win_done, acc_clr;
  win_cls_e         cls;
  logic             int_clear_q, loop_hold_q, locked_q;
  logic             int_clear_d, loop_hold_d, locked_d;
  gain_t            kp_q, ki_q, kp_d, ki_d;

  function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
    return (&v) ? v : v + RUN_W'(1);
  endfunction

  // Accumulators are held clear throughout CLEAR, including its entry clk.
  assign acc_clr = (cur == ST_CLEAR) || (nxt == ST_CLEAR);

  cdr_win_acc #(
    .WIN_LOG2 (WIN_LOG2),
    .LOCK_THR (LOCK_THR),
    .MIN_TRANS(MIN_TRANS)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (acc_clr),
    .sample_en(cdr.sample_en),
    .pd_up    (cdr.pd_up),
    .pd_dn    (cdr.pd_dn),
    .trans    (cdr.trans),
    .win_done (win_done),
    .cls      (cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= ST_CLEAR;
      quiet_run   <= '0;
      noisy_run   <= '0;
      int_clear_q <= 1'b0;
      loop_hold_q <= 1'b0;
      locked_q    <= 1'b0;
      kp_q        <= KP_A;
      ki_q        <= KI_A;
    end else begin
      cur         <= nxt;
      quiet_run   <= quiet_nxt;
      noisy_run   <= noisy_nxt;
      int_clear_q <= int_clear_d;
      loop_hold_q <= loop_hold_d;
      locked_q    <= locked_d;
      kp_q        <= kp_d;
      ki_q        <= ki_d;
    end
  end

  always_comb begin
    quiet_upd = quiet_run;
    noisy_upd = noisy_run;
    if (win_done) begin
      case (cls)
        CLS_QUIET: begin quiet_upd = sat_inc(quiet_run); noisy_upd = '0; end
        CLS_NOISY: begin noisy_upd = sat_inc(noisy_run); quiet_upd = '0; end
        default: ;
      endcase
    end
    nxt       = cur;
    quiet_nxt = quiet_upd;
    noisy_nxt = noisy_upd;
    if (!ena) begin
      nxt = ST_CLEAR;
    end else begin
      case (cur)
        // Stay one clk for the integrator clear pulse, then acquire.
        ST_CLEAR: if (int_clear_q) nxt = ST_ACQ;
        ST_ACQ: if (win_done && quiet_upd >= ACQ_N) begin
          nxt       = ST_TRACK;
          quiet_nxt = '0;
        end
        ST_TRACK: if (win_done && quiet_upd >= LOCK_N) begin
          nxt       = ST_LOCKED;
          quiet_nxt = '0;
        end else if (win_done && noisy_upd >= UNL_N) begin
          nxt       = ST_ACQ;
          noisy_nxt = '0;
        end
        ST_LOCKED: if (win_done && noisy_upd >= UNL_N) nxt = ST_CLEAR;
        default: nxt = ST_CLEAR;
      endcase
    end
    if (nxt == ST_CLEAR) begin
      quiet_nxt = '0;
      noisy_nxt = '0;
    end
  end

  always_comb begin
    int_clear_d = ena && (nxt == ST_CLEAR);
    loop_hold_d = loop_hold_q;
    if (win_done) loop_hold_d = (cls == CLS_NEUTRAL);
    if (nxt == ST_CLEAR) loop_hold_d = 1'b0;
    locked_d = (nxt == ST_LOCKED);
    kp_d     = trk_gain(nxt) ? KP_T : KP_A;
    ki_d     = trk_gain(nxt) ? KI_T : KI_A;
  end

  assign cdr.kp_shift  = kp_q;
  assign cdr.ki_shift  = ki_q;
  assign cdr.int_clear = int_clear_q;
  assign cdr.loop_hold = loop_hold_q;
  assign cdr.locked    = locked_q;
  assign cdr.state     = cur;
  assign cdr.win_done  = win_done;
endmodule

// File: tb/tb_cdr_lock_seq.sv
// Directed + randomized bench for cdr_lock_seq against a window-level
// reference model of the acquisition/lock rules.
module tb_cdr_lock_seq;
  import cdr_pkg::*;

  localparam int WL = 4, THR = 2, MINT = 4, AW = 2, LW = 4, UW = 2;
  localparam int WIN = 1 << WL;

  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
  int   n_chk = 0, n_fail = 0;
  int   ic_cnt = 0, wd_cnt = 0;

  // Reference model state (window level).
  int m_st, m_n, m_up, m_dn, m_tr, m_qr, m_nr, m_hold, m_clr, m_wd;

  cdr_lock_seq_if bus();

  cdr_lock_seq #(
    .WIN_LOG2(WL), .LOCK_THR(THR), .MIN_TRANS(MINT),
    .ACQ_WINS(AW), .LOCK_WINS(LW), .UNLOCK_WINS(UW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .cdr  (bus)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (bus.int_clear === 1'b1) ic_cnt++;
    if (bus.win_done === 1'b1) wd_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic model_flush();
    m_n = 0; m_up = 0; m_dn = 0; m_tr = 0; m_qr = 0; m_nr = 0; m_hold = 0;
  endtask

  task automatic model_step(input bit up, input bit dn, input bit tr);
    int net, mag;
    if (up && !dn) m_up++;
    if (dn && !up) m_dn++;
    if (tr) m_tr++;
    m_n++;
    if (m_n == WIN) begin
      net = m_up - m_dn;
      mag = (net < 0) ? -net : net;
      m_wd++;
      if (m_tr < MINT) m_hold = 1;
      else begin
        m_hold = 0;
        if (mag <= THR) begin m_qr++; m_nr = 0; end
        else begin m_nr++; m_qr = 0; end
      end
      m_n = 0; m_up = 0; m_dn = 0; m_tr = 0;
      if (m_st == 1 && m_qr >= AW) begin m_st = 2; m_qr = 0; end
      else if (m_st == 2 && m_qr >= LW) begin m_st = 3; m_qr = 0; end
      else if (m_st == 2 && m_nr >= UW) begin m_st = 1; m_nr = 0; end
      else if (m_st == 3 && m_nr >= UW) begin model_flush(); m_clr++; m_st = 1; end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(bus.state), m_st);
    chk({tag, ".kp"}, 32'(bus.kp_shift), (m_st >= 2) ? 5 : 3);
    chk({tag, ".ki"}, 32'(bus.ki_shift), (m_st >= 2) ? 10 : 6);
    chk({tag, ".locked"}, 32'(bus.locked), (m_st == 3) ? 1 : 0);
    chk({tag, ".hold"}, 32'(bus.loop_hold), m_hold);
    chk({tag, ".int_clear"}, 32'(bus.int_clear), 0);
    chk({tag, ".clr_pulses"}, ic_cnt, m_clr);
    chk({tag, ".win_dones"}, wd_cnt, m_wd);
  endtask

  task automatic drive(input bit up, input bit dn, input bit tr, input bit use_model);
    bus.sample_en = 1'b1; bus.pd_up = up; bus.pd_dn = dn; bus.trans = tr;
    if (use_model) model_step(up, dn, tr);
    @(negedge clk);
    bus.sample_en = 1'b0; bus.pd_up = 1'b0; bus.pd_dn = 1'b0; bus.trans = 1'b0;
  endtask

  task automatic do_strobe(input string tag, input bit up, input bit dn, input bit tr);
    drive(up, dn, tr, 1'b1);
    repeat (3) @(negedge clk);
    check_all(tag);
  endtask

  // kind: 0 quiet, 1 noisy, 2 neutral (directed); 3..5 randomized variants; 6 free random
  task automatic window(input string tag, input int kind);
    bit up, dn, tr;
    int r;
    for (int i = 0; i < WIN; i++) begin
      r = $urandom_range(0, 3);
      case (kind)
        0: begin up = i[0]; dn = !i[0]; tr = 1'b1; end
        1: begin up = 1'b1; dn = 1'b0; tr = 1'b1; end
        2: begin up = i[0]; dn = !i[0]; tr = 1'b0; end
        3: begin
          up = (r == 2) || ((r == 0) ^ i[0]); dn = (r == 2) || ((r == 1) ^ i[0]);
          if (r == 3) begin up = 1'b0; dn = 1'b0; end
          tr = ($urandom_range(0, 7) != 0);
        end
        4: begin up = ($urandom_range(0, 7) != 0); dn = !up && r[0]; tr = ($urandom_range(0, 3) != 0); end
        5: begin up = r[0]; dn = r[1]; tr = ($urandom_range(0, 15) == 0); end
        default: begin up = r[0]; dn = r[1]; tr = ($urandom_range(0, 1) != 0); end
      endcase
      do_strobe(tag, up, dn, tr);
    end
  endtask

  initial begin
    bus.sample_en = 1'b0; bus.pd_up = 1'b0; bus.pd_dn = 1'b0; bus.trans = 1'b0;
    m_st = 0; m_clr = 0; m_wd = 0; model_flush();

    // Reset values
    #35;
    chk("rst.state", 32'(bus.state), 0);
    chk("rst.kp", 32'(bus.kp_shift), 3);
    chk("rst.ki", 32'(bus.ki_shift), 6);
    chk("rst.int_clear", 32'(bus.int_clear), 0);
    chk("rst.hold", 32'(bus.loop_hold), 0);
    chk("rst.locked", 32'(bus.locked), 0);
    chk("rst.win_done", 32'(bus.win_done), 0);

    // 1: release reset with ena=1, expect one clear pulse then ACQ
    @(negedge clk);
    rst_n = 1'b1; ena = 1'b1;
    @(negedge clk);
    chk("s1.clear_state", 32'(bus.state), 0);
    chk("s1.clear_pulse", 32'(bus.int_clear), 1);
    @(negedge clk);
    m_clr++; m_st = 1;
    chk("s1.acq_state", 32'(bus.state), 1);
    check_all("s1");

    // 2: balanced windows: ACQ -> TRACK -> LOCKED
    repeat (2) window("s2a", 0);
    chk("s2.track", 32'(bus.state), 2);
    chk("s2.kp_trk", 32'(bus.kp_shift), 5);
    chk("s2.ki_trk", 32'(bus.ki_shift), 10);
    repeat (4) window("s2b", 0);
    chk("s2.locked_state", 32'(bus.state), 3);
    chk("s2.locked", 32'(bus.locked), 1);

    // 3: two noisy windows from LOCKED -> CLEAR -> ACQ, cycle by cycle at the end
    window("s3a", 1);
    for (int i = 0; i < WIN - 1; i++) do_strobe("s3b", 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    chk("s3.win_done", 32'(bus.win_done), 1);
    chk("s3.pre_state", 32'(bus.state), 3);
    @(negedge clk);
    chk("s3.clear_state", 32'(bus.state), 0);
    chk("s3.clear_pulse", 32'(bus.int_clear), 1);
    chk("s3.unlocked", 32'(bus.locked), 0);
    chk("s3.kp_acq", 32'(bus.kp_shift), 3);
    @(negedge clk);
    chk("s3.acq_state", 32'(bus.state), 1);
    @(negedge clk);
    check_all("s3");

    // 4: in TRACK, noisy/quiet/noisy must not fall back (noisy_run resets)
    repeat (2) window("s4a", 0);
    window("s4n1", 1);
    chk("s4.track1", 32'(bus.state), 2);
    window("s4q", 0);
    window("s4n2", 1);
    chk("s4.track2", 32'(bus.state), 2);

    // 5: neutral window holds the loop without breaking the quiet run
    repeat (2) window("s5a", 0);
    window("s5n", 2);
    chk("s5.hold", 32'(bus.loop_hold), 1);
    chk("s5.track", 32'(bus.state), 2);
    window("s5q", 0);
    chk("s5.unhold", 32'(bus.loop_hold), 0);
    chk("s5.still_track", 32'(bus.state), 2);
    window("s5l", 0);
    chk("s5.locked_state", 32'(bus.state), 3);
    chk("s5.locked", 32'(bus.locked), 1);

    // 6: drop ena mid-window in LOCKED; strobes while disabled are ignored
    for (int i = 0; i < 5; i++) do_strobe("s6a", i[0], !i[0], 1'b1);
    ena = 1'b0;
    @(negedge clk);
    chk("s6.clear_state", 32'(bus.state), 0);
    chk("s6.unlocked", 32'(bus.locked), 0);
    chk("s6.no_pulse", 32'(bus.int_clear), 0);
    chk("s6.hold", 32'(bus.loop_hold), 0);
    model_flush(); m_st = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
    end
    chk("s6.held_state", 32'(bus.state), 0);
    chk("s6.held_pulses", ic_cnt, m_clr);
    ena = 1'b1;
    m_clr++; m_st = 1;
    repeat (3) @(negedge clk);
    check_all("s6b");

    // Randomized windows against the model
    for (int w = 0; w < 24; w++) begin
      int r;
      r = $urandom_range(0, 9);
      window("rnd", (r < 5) ? 3 : (r < 8) ? 4 : (r == 8) ? 5 : 6);
    end

    // Asynchronous reset mid-window
    for (int i = 0; i < 7; i++) do_strobe("pre_rst", 1'b1, 1'b0, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst.state", 32'(bus.state), 0);
    chk("arst.kp", 32'(bus.kp_shift), 3);
    chk("arst.ki", 32'(bus.ki_shift), 6);
    chk("arst.locked", 32'(bus.locked), 0);
    chk("arst.hold", 32'(bus.loop_hold), 0);
    chk("arst.int_clear", 32'(bus.int_clear), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_flush(); m_st = 0;
    m_clr++; m_st = 1;
    repeat (3) @(negedge clk);
    check_all("arst_rel");
    repeat (8) window("post", $urandom_range(3, 4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
